compare_stream: RTL and testbench
=================================

Name: compare_stream

Overview:
- Parametrised, registered successor to the team's 4-bit magnitude comparator. Same six-flag result word, now for any operand width, with a signed/unsigned mode.
- Accepts operand pairs over a valid/ready handshake and presents one registered result per accepted pair.
- Keeps running statistics over the accepted stream: min/max of A, count of equal pairs, and total sample count.
- Sits between an operand source (testbench, counter, switch bank) and a display/scoreboard consumer.

Parameters:
WIDTH, 4, operand width in bits (>=2)
SIGNED, 0, 1 = operands are two's complement; 0 = unsigned
CNT_W, 8, width of the eq_count and sample_count counters (>=2)

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-high reset
in_valid  input  1  A/B pair is presented
in_ready  output  1  block can accept a pair this cycle
A  input  WIDTH  operand A
B  input  WIDTH  operand B
clear  input  1  synchronous restart of statistics only
out_valid  output  1  Y holds an unconsumed result
out_ready  input  1  consumer takes Y this cycle
Y  output  6  [5]=eq [4]=ne [3]=gt [2]=lt [1]=ge [0]=le, all for A relative to B
min_a  output  WIDTH  smallest A since reset or clear
max_a  output  WIDTH  largest A since reset or clear
eq_count  output  CNT_W  accepted pairs with A==B
sample_count  output  CNT_W  accepted pairs
overflow  output  1  sticky; set when either counter saturates

Behaviour:
- Reset (asynchronous, takes effect immediately): out_valid=0, Y=0, min_a=0, max_a=0, eq_count=0, sample_count=0, overflow=0, tracker state EMPTY.
- Comparison mode: SIGNED=1 compares A and B as two's complement; SIGNED=0 compares them unsigned. The min/max tracker uses the same mode.
- Flag consistency: eq^ne=1 always. gt, lt and eq are mutually exclusive. ge=gt|eq and le=lt|eq.
- Handshake: in_ready = !out_valid | out_ready (combinational).
- An accept happens when in_valid & in_ready.
- On an accept, Y is registered from that A/B and out_valid=1 on the next edge. Latency is 1 cycle, and back-to-back accepts give full throughput.
- Output stability: while out_valid & !out_ready, Y holds and in_ready=0.
- Output drain: if out_ready=1 with no accept, out_valid drops to 0 on the next edge.
- Tracker FSM, EMPTY:
  - on accept: min_a=max_a=A, sample_count=1, eq_count=(A==B), then go to TRACK.
- Tracker FSM, TRACK:
  - on accept: min_a=min(min_a,A), max_a=max(max_a,A), sample_count+1, eq_count+1 if A==B.
  - on clear without accept: go to EMPTY, with min_a, max_a, eq_count, sample_count and overflow all 0.
- clear and accept in the same cycle: statistics restart with that sample, exactly the EMPTY-accept update; overflow is cleared.
- clear never affects Y, out_valid or the handshake.
- Saturation: each counter stops at 2^CNT_W-1. An accept that would exceed that value sets overflow, which stays set until clear or reset.
- Reset mid-transfer: a pending result is discarded, and out_valid=0 after reset.

Test Plan:
- WIDTH=4, SIGNED=0, out_ready=1; accept A=9,B=3 then A=5,B=5 then A=2,B=7 -> Y=011010, 100011, 010101 on consecutive cycles after 1-cycle latency.
- WIDTH=4, SIGNED=1; A=4'b1110 (-2), B=4'b0001 (1) -> Y=010101 (lt, ne, le); same pair with SIGNED=0 -> Y=011010.
- Backpressure: hold out_ready=0 after one accept, keep in_valid=1 -> in_ready=0 and Y unchanged for 5 cycles. Release -> the next pair is accepted in the same cycle out_ready=1.
- Stats: A sequence 6,2,9,2 with B=2 each -> min_a=2, max_a=9, eq_count=2, sample_count=4. Assert clear alone -> all zero next cycle. Clear together with accept A=7,B=7 -> min=max=7, counts 1/1.
- Saturation: CNT_W=2, 4 accepts with A==B -> counts stop at 3 and overflow=1 after the 4th accept. Then clear -> overflow=0.
- Assert reset asynchronously mid-stream with out_valid=1 -> outputs reach reset values before the next clock edge.

Source files
------------

// File: rtl/compare_stream.sv
// Registered magnitude comparator on a valid/ready stream, with running
// min/max of A and saturating equal/sample counters.
module compare_stream #(
    parameter int WIDTH  = 4,
    parameter bit SIGNED = 1'b0,
    parameter int CNT_W  = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             clear,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [5:0]       Y,
    output logic [WIDTH-1:0] min_a,
    output logic [WIDTH-1:0] max_a,
    output logic [CNT_W-1:0] eq_count,
    output logic [CNT_W-1:0] sample_count,
    output logic             overflow,
    output logic             dbg_tracking
);

    // Handshake: a pair moves on a cycle where in_valid & in_ready; a result
    // moves on a cycle where out_valid & out_ready. in_ready is
    // !out_valid | out_ready, so Y never changes while it is stalled.

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_TRACK = 1'b1
    } track_state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    track_state_t     state_q;
    logic             out_valid_q;
    logic [5:0]       y_q;
    logic [5:0]       y_d;
    logic [WIDTH-1:0] min_q;
    logic [WIDTH-1:0] max_q;
    logic [CNT_W-1:0] eq_q;
    logic [CNT_W-1:0] cnt_q;
    logic             ovf_q;

    logic accept;
    logic a_eq_b;
    logic a_lt_b;
    logic a_gt_b;
    logic restart;

    function automatic logic less(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
        if (SIGNED) begin
            return $signed(x) < $signed(y);
        end
        return x < y;
    endfunction

    assign in_ready = !out_valid_q || out_ready;
    assign accept   = in_valid && in_ready;

    assign a_eq_b = (A == B);
    assign a_lt_b = less(A, B);
    assign a_gt_b = less(B, A);
    assign y_d    = {a_eq_b, !a_eq_b, a_gt_b, a_lt_b, a_gt_b || a_eq_b, a_lt_b || a_eq_b};

    // A clear in the same cycle as an accept restarts with that sample.
    assign restart = accept && (clear || (state_q == ST_EMPTY));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid_q <= 1'b0;
            y_q         <= '0;
        end else if (accept) begin
            out_valid_q <= 1'b1;
            y_q         <= y_d;
        end else if (out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_EMPTY;
            min_q   <= '0;
            max_q   <= '0;
            eq_q    <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
        end else if (restart) begin
            state_q <= ST_TRACK;
            min_q   <= A;
            max_q   <= A;
            cnt_q   <= CNT_ONE;
            eq_q    <= a_eq_b ? CNT_ONE : '0;
            ovf_q   <= 1'b0;
        end else if (clear) begin
            state_q <= ST_EMPTY;
            min_q   <= '0;
            max_q   <= '0;
            eq_q    <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
        end else if (accept) begin
            if (less(A, min_q)) begin
                min_q <= A;
            end
            if (less(max_q, A)) begin
                max_q <= A;
            end
            // Counters stick at all-ones; the accept that would wrap flags overflow.
            if (cnt_q != CNT_MAX) begin
                cnt_q <= cnt_q + CNT_ONE;
            end else begin
                ovf_q <= 1'b1;
            end
            if (a_eq_b) begin
                if (eq_q != CNT_MAX) begin
                    eq_q <= eq_q + CNT_ONE;
                end else begin
                    ovf_q <= 1'b1;
                end
            end
        end
    end

    assign out_valid    = out_valid_q;
    assign Y            = y_q;
    assign min_a        = min_q;
    assign max_a        = max_q;
    assign eq_count     = eq_q;
    assign sample_count = cnt_q;
    assign overflow     = ovf_q;
    assign dbg_tracking = (state_q == ST_TRACK);

endmodule

// File: tb/tb_compare_stream.sv
// Bench for compare_stream: three instances (unsigned, signed, 2-bit counters)
// share one input stream and are checked against a history-based model.
module tb_compare_stream;

    logic       clk = 1'b0;
    logic       reset;
    logic       in_valid;
    logic       clear;
    logic       out_ready;
    logic [3:0] A;
    logic [3:0] B;

    logic       in_ready_o [3];
    logic       out_valid_o[3];
    logic [5:0] y_o        [3];
    logic [3:0] min_o      [3];
    logic [3:0] max_o      [3];
    logic [7:0] eqc_o      [3];
    logic [7:0] cnt_o      [3];
    logic       ovf_o      [3];
    logic       trk_o      [3];
    logic [1:0] eqc_sat;
    logic [1:0] cnt_sat;

    always #5 clk = ~clk;

    compare_stream #(.WIDTH(4), .SIGNED(1'b0), .CNT_W(8)) u_uns (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_o[0]),
        .A(A), .B(B), .clear(clear), .out_valid(out_valid_o[0]), .out_ready(out_ready),
        .Y(y_o[0]), .min_a(min_o[0]), .max_a(max_o[0]), .eq_count(eqc_o[0]),
        .sample_count(cnt_o[0]), .overflow(ovf_o[0]), .dbg_tracking(trk_o[0])
    );

    compare_stream #(.WIDTH(4), .SIGNED(1'b1), .CNT_W(8)) u_sgn (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_o[1]),
        .A(A), .B(B), .clear(clear), .out_valid(out_valid_o[1]), .out_ready(out_ready),
        .Y(y_o[1]), .min_a(min_o[1]), .max_a(max_o[1]), .eq_count(eqc_o[1]),
        .sample_count(cnt_o[1]), .overflow(ovf_o[1]), .dbg_tracking(trk_o[1])
    );

    compare_stream #(.WIDTH(4), .SIGNED(1'b0), .CNT_W(2)) u_sat (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_o[2]),
        .A(A), .B(B), .clear(clear), .out_valid(out_valid_o[2]), .out_ready(out_ready),
        .Y(y_o[2]), .min_a(min_o[2]), .max_a(max_o[2]), .eq_count(eqc_sat),
        .sample_count(cnt_sat), .overflow(ovf_o[2]), .dbg_tracking(trk_o[2])
    );

    assign eqc_o[2] = {6'b0, eqc_sat};
    assign cnt_o[2] = {6'b0, cnt_sat};

    // ---------------- scoreboard / reference model ----------------
    int          n_vec = 0;
    int          n_bad = 0;
    logic [11:0] exp_q[$];     // {unsigned flags, signed flags} per unconsumed result
    logic [11:0] last_y;
    bit          m_valid;
    logic [3:0]  hist[$];      // every A accepted since reset/clear
    int          n_samp;
    int          n_eq;

    function automatic int val(input logic [3:0] x, input bit sgn);
        if (sgn) return int'($signed(x));
        return int'(x);
    endfunction

    function automatic logic [5:0] flags(input logic [3:0] a, input logic [3:0] b, input bit sgn);
        int  ia;
        int  ib;
        bit  eq;
        bit  gt;
        bit  lt;
        ia = val(a, sgn);
        ib = val(b, sgn);
        eq = (ia == ib);
        gt = (ia > ib);
        lt = (ia < ib);
        return {eq, !eq, gt, lt, gt | eq, lt | eq};
    endfunction

    function automatic logic [3:0] extreme(input bit sgn, input bit want_max);
        logic [3:0] best;
        if (hist.size() == 0) return 4'd0;
        best = hist[0];
        foreach (hist[i]) begin
            if (want_max ? (val(hist[i], sgn) > val(best, sgn)) : (val(hist[i], sgn) < val(best, sgn)))
                best = hist[i];
        end
        return best;
    endfunction

    function automatic int sat(input int n, input int cap);
        return (n > cap) ? cap : n;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        hist.delete();
        last_y  = '0;
        m_valid = 1'b0;
        n_samp  = 0;
        n_eq    = 0;
    endtask

    task automatic check_all();
        logic [5:0] ey;
        bit         sgn;
        int         cap;
        for (int k = 0; k < 3; k++) begin
            sgn = (k == 1);
            cap = (k == 2) ? 3 : 255;
            ey  = (k == 1) ? last_y[5:0] : last_y[11:6];
            if (m_valid) ey = (k == 1) ? exp_q[0][5:0] : exp_q[0][11:6];
            chk($sformatf("out_valid[%0d]", k), 32'(out_valid_o[k]), 32'(m_valid));
            chk($sformatf("Y[%0d]", k), 32'(y_o[k]), 32'(ey));
            chk($sformatf("min_a[%0d]", k), 32'(min_o[k]), 32'(extreme(sgn, 1'b0)));
            chk($sformatf("max_a[%0d]", k), 32'(max_o[k]), 32'(extreme(sgn, 1'b1)));
            chk($sformatf("eq_count[%0d]", k), 32'(eqc_o[k]), 32'(sat(n_eq, cap)));
            chk($sformatf("sample_count[%0d]", k), 32'(cnt_o[k]), 32'(sat(n_samp, cap)));
            chk($sformatf("overflow[%0d]", k), 32'(ovf_o[k]), 32'(n_samp > cap));
            chk($sformatf("tracking[%0d]", k), 32'(trk_o[k]), 32'(hist.size() > 0));
        end
    endtask

    // Inputs are set at a negedge; this runs one clock and checks everything.
    task automatic cycle();
        bit acc;
        #1;
        for (int k = 0; k < 3; k++)
            chk($sformatf("in_ready[%0d]", k), 32'(in_ready_o[k]), 32'(!m_valid || out_ready));
        acc = in_valid && (!m_valid || out_ready);
        @(posedge clk);
        if (m_valid && out_ready) void'(exp_q.pop_front());
        if (acc) begin
            last_y = {flags(A, B, 1'b0), flags(A, B, 1'b1)};
            exp_q.push_back(last_y);
            m_valid = 1'b1;
        end else if (out_ready) begin
            m_valid = 1'b0;
        end
        if (clear) begin
            hist.delete();
            n_samp = 0;
            n_eq   = 0;
        end
        if (acc) begin
            hist.push_back(A);
            n_samp++;
            if (A == B) n_eq++;
        end
        @(negedge clk);
        check_all();
    endtask

    task automatic drive(input bit v, input logic [3:0] a, input logic [3:0] b, input bit c);
        in_valid = v;
        A        = a;
        B        = b;
        clear    = c;
        cycle();
    endtask

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic [5:0] yu;
        logic [5:0] ys;
    } vec_t;

    vec_t tbl[8];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = '{4'd9,  4'd3,  6'b011010, 6'b010101};
        tbl[1] = '{4'd5,  4'd5,  6'b100011, 6'b100011};
        tbl[2] = '{4'd2,  4'd7,  6'b010101, 6'b010101};
        tbl[3] = '{4'd14, 4'd1,  6'b011010, 6'b010101};
        tbl[4] = '{4'd8,  4'd7,  6'b011010, 6'b010101};
        tbl[5] = '{4'd7,  4'd8,  6'b010101, 6'b011010};
        tbl[6] = '{4'd0,  4'd15, 6'b010101, 6'b011010};
        tbl[7] = '{4'd15, 4'd15, 6'b100011, 6'b100011};

        // ---- clock/reset ----
        reset = 1'b1; in_valid = 1'b0; clear = 1'b0; out_ready = 1'b1; A = '0; B = '0;
        model_reset();
        repeat (2) @(negedge clk);
        check_all();
        reset = 1'b0;

        // ---- table: one pair per cycle, constant expected flags ----
        foreach (tbl[i]) begin
            drive(1'b1, tbl[i].a, tbl[i].b, 1'b0);
            chk($sformatf("tbl%0d_y_uns", i), 32'(y_o[0]), 32'(tbl[i].yu));
            chk($sformatf("tbl%0d_y_sgn", i), 32'(y_o[1]), 32'(tbl[i].ys));
        end
        drive(1'b0, 4'd0, 4'd0, 1'b0);

        // ---- backpressure ----
        drive(1'b1, 4'd3, 4'd12, 1'b0);
        out_ready = 1'b0;
        repeat (5) begin
            drive(1'b1, 4'd10, 4'd10, 1'b0);
            chk("bp_in_ready", 32'(in_ready_o[0]), 32'd0);
            chk("bp_y_hold", 32'(y_o[0]), 32'(6'b010101));
        end
        out_ready = 1'b1;
        drive(1'b1, 4'd10, 4'd10, 1'b0);
        chk("bp_release_y", 32'(y_o[0]), 32'(6'b100011));

        // ---- statistics, clear, clear+accept ----
        drive(1'b1, 4'd6, 4'd2, 1'b1);
        drive(1'b1, 4'd2, 4'd2, 1'b0);
        drive(1'b1, 4'd9, 4'd2, 1'b0);
        drive(1'b1, 4'd2, 4'd2, 1'b0);
        drive(1'b0, 4'd0, 4'd0, 1'b0);
        chk("st_min", 32'(min_o[0]), 32'd2);
        chk("st_max", 32'(max_o[0]), 32'd9);
        chk("st_eq", 32'(eqc_o[0]), 32'd2);
        chk("st_cnt", 32'(cnt_o[0]), 32'd4);
        chk("st_sat_cnt", 32'(cnt_o[2]), 32'd3);
        chk("st_sat_ovf", 32'(ovf_o[2]), 32'd1);
        drive(1'b0, 4'd0, 4'd0, 1'b1);
        chk("clr_min", 32'(min_o[0]), 32'd0);
        chk("clr_max", 32'(max_o[0]), 32'd0);
        chk("clr_cnt", 32'(cnt_o[0]), 32'd0);
        chk("clr_ovf", 32'(ovf_o[2]), 32'd0);
        drive(1'b1, 4'd7, 4'd7, 1'b1);
        chk("ca_min", 32'(min_o[0]), 32'd7);
        chk("ca_max", 32'(max_o[0]), 32'd7);
        chk("ca_eq", 32'(eqc_o[0]), 32'd1);
        chk("ca_cnt", 32'(cnt_o[0]), 32'd1);

        // ---- saturation of the 2-bit counters ----
        drive(1'b1, 4'd5, 4'd5, 1'b1);
        drive(1'b1, 4'd1, 4'd1, 1'b0);
        drive(1'b1, 4'd2, 4'd2, 1'b0);
        chk("sat3_cnt", 32'(cnt_o[2]), 32'd3);
        chk("sat3_ovf", 32'(ovf_o[2]), 32'd0);
        drive(1'b1, 4'd3, 4'd3, 1'b0);
        chk("sat4_cnt", 32'(cnt_o[2]), 32'd3);
        chk("sat4_eq", 32'(eqc_o[2]), 32'd3);
        chk("sat4_ovf", 32'(ovf_o[2]), 32'd1);
        drive(1'b0, 4'd0, 4'd0, 1'b1);
        chk("sat_clr_ovf", 32'(ovf_o[2]), 32'd0);

        // ---- asynchronous reset with a stalled result ----
        out_ready = 1'b0;
        drive(1'b1, 4'd9, 4'd3, 1'b0);
        drive(1'b0, 4'd0, 4'd0, 1'b0);
        chk("ar_pre_valid", 32'(out_valid_o[0]), 32'd1);
        #1 reset = 1'b1;
        #1;
        chk("ar_valid", 32'(out_valid_o[0]), 32'd0);
        chk("ar_y", 32'(y_o[0]), 32'd0);
        chk("ar_cnt", 32'(cnt_o[0]), 32'd0);
        chk("ar_max", 32'(max_o[0]), 32'd0);
        model_reset();
        @(negedge clk);
        check_all();
        reset = 1'b0;
        out_ready = 1'b1;

        // ---- randomized stream ----
        for (int i = 0; i < 400; i++) begin
            logic [3:0] ra;
            logic [3:0] rb;
            ra = 4'($urandom_range(0, 15));
            rb = ($urandom_range(0, 3) == 0) ? ra : 4'($urandom_range(0, 15));
            out_ready = ($urandom_range(0, 3) != 0);
            drive($urandom_range(0, 3) != 0, ra, rb, $urandom_range(0, 20) == 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
